cipher_ctrl: RTL and testbench

CIPHER_CTRL -- requirements
Module: cipher_ctrl

---
 rtl/cipher_pkg.sv | 29 ++
 rtl/cipher_ctrl_if.sv | 24 ++
 rtl/cipher_tx_seq.sv | 64 ++++++
 rtl/cipher_ctrl.sv | 162 ++++++++++++++++
 tb/tb_cipher_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cipher_pkg.sv
// rtl/cipher_pkg.sv - shared command/reply codes, FSM encoding and reply descriptor
package cipher_pkg;

    localparam logic [7:0] CMD_KEY = 8'h4B;
    localparam logic [7:0] CMD_ENC = 8'h45;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h3F;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RX_KEY  = 3'd1;
    localparam logic [2:0] ST_RX_BLK  = 3'd2;
    localparam logic [2:0] ST_SETTLE  = 3'd3;
    localparam logic [2:0] ST_TX_REQ  = 3'd4;
    localparam logic [2:0] ST_TX_WAIT = 3'd5;

    // Reply bytes are left-justified: the first byte sent is bytes[63:56].
    typedef struct packed {
        logic [63:0] bytes;
        logic [5:0]  len;
    } reply_t;

    function automatic reply_t one_byte(input logic [7:0] b);
        reply_t r;
        r.bytes = {b, 56'h0};
        r.len   = 6'd1;
        return r;
    endfunction

endpackage

// File: rtl/cipher_ctrl_if.sv
// rtl/cipher_ctrl_if.sv - UART byte streams and cipher datapath bundle
interface cipher_ctrl_if;
    logic [7:0]   RX_DATA;
    logic         RX_READY;
    logic [7:0]   TX_DATA;
    logic         TX_START;
    logic         TX_BUSY;
    logic [63:0]  FN_IN;
    logic [255:0] FN_KEY;
    logic [63:0]  FN_OUT;
    logic [63:0]  LAST_OUT;
    logic         BUSY;
    logic         ERR;

    modport master (
        output RX_DATA, RX_READY, TX_BUSY, FN_OUT,
        input  TX_DATA, TX_START, FN_IN, FN_KEY, LAST_OUT, BUSY, ERR
    );

    modport slave (
        input  RX_DATA, RX_READY, TX_BUSY, FN_OUT,
        output TX_DATA, TX_START, FN_IN, FN_KEY, LAST_OUT, BUSY, ERR
    );
endinterface

// File: rtl/cipher_tx_seq.sv
// rtl/cipher_tx_seq.sv - reply serializer: start/busy handshake and reply byte counter
module cipher_tx_seq
    import cipher_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       load_i,
    input  reply_t     reply_i,
    input  logic       in_req_i,
    input  logic       in_wait_i,
    input  logic       tx_busy_i,
    output logic [7:0] tx_data_o,
    output logic       tx_start_o,
    output logic       issue_o,
    output logic       next_o,
    output logic       done_o
);
    logic [63:0] buf_q;
    logic [5:0]  idx_q;
    logic [5:0]  len_q;
    logic        seen_busy_q;
    logic        start_q;
    logic [7:0]  data_q;
    logic        finish;
    logic        is_last;

    // A byte is finished only after the transmitter has gone busy and then idle again.
    assign issue_o = in_req_i && !tx_busy_i;
    assign finish  = in_wait_i && seen_busy_q && !tx_busy_i;
    assign is_last = (idx_q == len_q - 6'd1);
    assign next_o  = finish && !is_last;
    assign done_o  = finish && is_last;

    always_ff @(posedge CLK) begin
        if (RST) begin
            buf_q       <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            seen_busy_q <= 1'b0;
            start_q     <= 1'b0;
            data_q      <= '0;
        end else begin
            start_q <= issue_o;
            if (load_i) begin
                buf_q <= reply_i.bytes;
                len_q <= reply_i.len;
                idx_q <= '0;
            end
            if (issue_o) begin
                data_q      <= buf_q[63:56];
                seen_busy_q <= 1'b0;
            end else if (in_wait_i && tx_busy_i) begin
                seen_busy_q <= 1'b1;
            end
            if (next_o) begin
                idx_q <= idx_q + 6'd1;
                buf_q <= {buf_q[55:0], 8'h00};
            end
        end
    end

    assign tx_data_o  = data_q;
    assign tx_start_o = start_q;
endmodule

// File: rtl/cipher_ctrl.sv
// rtl/cipher_ctrl.sv - UART command front end for a combinational cipher datapath
module cipher_ctrl
    import cipher_pkg::*;
#(
    parameter int unsigned  SETTLE_CYCLES = 7,
    parameter int unsigned  RX_TIMEOUT    = 50_000_000,
    parameter logic [255:0] KEY_INIT      = 256'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100
) (
    input  logic         CLK,
    input  logic         RST,
    cipher_ctrl_if.slave bus
);
    localparam logic [31:0] TO_LAST     = 32'(RX_TIMEOUT - 1);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    logic [2:0]   state_q, state_d;
    logic [5:0]   rx_cnt_q, rx_cnt_d;
    logic [31:0]  timer_q, timer_d;
    logic [7:0]   settle_q, settle_d;
    logic [247:0] stage_q, stage_d;
    logic [255:0] fn_key_q, fn_key_d;
    logic [63:0]  fn_in_q, fn_in_d;
    logic [63:0]  last_q, last_d;
    logic         err_q, err_d;
    logic         load;
    reply_t       reply;
    logic         seq_issue, seq_next, seq_done;
    logic         in_req, in_wait;
    logic [7:0]   tx_data;
    logic         tx_start;

    assign in_req  = (state_q == ST_TX_REQ);
    assign in_wait = (state_q == ST_TX_WAIT);

    always_comb begin
        state_d  = state_q;
        rx_cnt_d = rx_cnt_q;
        timer_d  = timer_q;
        settle_d = settle_q;
        stage_d  = stage_q;
        fn_key_d = fn_key_q;
        fn_in_d  = fn_in_q;
        last_d   = last_q;
        err_d    = 1'b0;
        load     = 1'b0;
        reply    = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.RX_READY) begin
                    rx_cnt_d = '0;
                    timer_d  = '0;
                    case (bus.RX_DATA)
                        CMD_KEY: state_d = ST_RX_KEY;
                        CMD_ENC: state_d = ST_RX_BLK;
                        default: begin
                            err_d   = 1'b1;
                            load    = 1'b1;
                            reply   = one_byte(RSP_NAK);
                            state_d = ST_TX_REQ;
                        end
                    endcase
                end
            end
            ST_RX_KEY, ST_RX_BLK: begin
                // An arriving byte wins over a timeout landing on the same cycle.
                if (bus.RX_READY) begin
                    stage_d  = {stage_q[239:0], bus.RX_DATA};
                    timer_d  = '0;
                    rx_cnt_d = rx_cnt_q + 6'd1;
                    if (state_q == ST_RX_KEY && rx_cnt_q == 6'd31) begin
                        fn_key_d = {stage_q, bus.RX_DATA};
                        load     = 1'b1;
                        reply    = one_byte(RSP_ACK);
                        rx_cnt_d = '0;
                        state_d  = ST_TX_REQ;
                    end else if (state_q == ST_RX_BLK && rx_cnt_q == 6'd7) begin
                        fn_in_d  = {stage_q[55:0], bus.RX_DATA};
                        settle_d = '0;
                        rx_cnt_d = '0;
                        state_d  = ST_SETTLE;
                    end
                end else if (timer_q == TO_LAST) begin
                    err_d    = 1'b1;
                    rx_cnt_d = '0;
                    timer_d  = '0;
                    state_d  = ST_IDLE;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            ST_SETTLE: begin
                err_d = bus.RX_READY;
                if (settle_q == SETTLE_LAST) begin
                    last_d      = bus.FN_OUT;
                    load        = 1'b1;
                    reply.bytes = bus.FN_OUT;
                    reply.len   = 6'd8;
                    state_d     = ST_TX_REQ;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            ST_TX_REQ: begin
                err_d = bus.RX_READY;
                if (seq_issue) state_d = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                err_d = bus.RX_READY;
                if (seq_done)      state_d = ST_IDLE;
                else if (seq_next) state_d = ST_TX_REQ;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            rx_cnt_q <= '0;
            timer_q  <= '0;
            settle_q <= '0;
            stage_q  <= '0;
            fn_key_q <= KEY_INIT;
            fn_in_q  <= '0;
            last_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rx_cnt_q <= rx_cnt_d;
            timer_q  <= timer_d;
            settle_q <= settle_d;
            stage_q  <= stage_d;
            fn_key_q <= fn_key_d;
            fn_in_q  <= fn_in_d;
            last_q   <= last_d;
            err_q    <= err_d;
        end
    end

    cipher_tx_seq u_tx_seq (
        .CLK        (CLK),
        .RST        (RST),
        .load_i     (load),
        .reply_i    (reply),
        .in_req_i   (in_req),
        .in_wait_i  (in_wait),
        .tx_busy_i  (bus.TX_BUSY),
        .tx_data_o  (tx_data),
        .tx_start_o (tx_start),
        .issue_o    (seq_issue),
        .next_o     (seq_next),
        .done_o     (seq_done)
    );

    assign bus.TX_DATA  = tx_data;
    assign bus.TX_START = tx_start;
    assign bus.FN_IN    = fn_in_q;
    assign bus.FN_KEY   = fn_key_q;
    assign bus.LAST_OUT = last_q;
    assign bus.BUSY     = (state_q != ST_IDLE);
    assign bus.ERR      = err_q;
endmodule

// File: tb/tb_cipher_ctrl.sv
// tb/tb_cipher_ctrl.sv - self-checking bench for cipher_ctrl
module tb_cipher_ctrl;
    import cipher_pkg::*;

    localparam int           SETTLE  = 7;
    localparam int           TIMEOUT = 40;
    localparam logic [255:0] KEY0    = 256'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100;

    typedef struct {
        logic [7:0]  cmd;
        logic [63:0] blk;
        logic [63:0] exp;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   err_cnt = 0;
    int   tx_cnt = 0;
    logic [7:0]   exp_q[$];
    logic [255:0] cur_key;
    logic [63:0]  cur_blk;
    vec_t         vecs[6];

    cipher_ctrl_if bus();

    cipher_ctrl #(.SETTLE_CYCLES(SETTLE), .RX_TIMEOUT(TIMEOUT), .KEY_INIT(KEY0)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [63:0] ref_fn(input logic [63:0] blk, input logic [255:0] key);
        return {blk[31:0], blk[63:32]} ^ key[63:0] ^ key[255:192];
    endfunction

    assign bus.FN_OUT = ref_fn(bus.FN_IN, bus.FN_KEY);

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every TX_START must match the next queued reply byte.
    initial forever begin
        @(negedge CLK);
        if (bus.ERR === 1'b1) err_cnt++;
        if (bus.TX_START === 1'b1) begin
            tx_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL tx_unexpected: got byte %0h expected no transmit", bus.TX_DATA);
            end else begin
                check("tx_byte", {248'h0, bus.TX_DATA}, {248'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        bus.TX_BUSY = 1'b0;
        forever begin
            @(negedge CLK);
            if (bus.TX_START === 1'b1) begin
                bus.TX_BUSY = 1'b1;
                repeat (4) @(negedge CLK);
                bus.TX_BUSY = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        bus.RX_DATA  = b;
        bus.RX_READY = 1'b1;
        @(negedge CLK);
        bus.RX_READY = 1'b0;
    endtask

    task automatic push_reply(input logic [63:0] v);
        for (int b = 7; b >= 0; b--) exp_q.push_back(v[b*8 +: 8]);
    endtask

    // Returns on the negedge where the first reply TX_START is visible.
    task automatic send_block(input logic [63:0] blk);
        int n;
        send_byte(CMD_ENC);
        for (int b = 7; b >= 1; b--) send_byte(blk[b*8 +: 8]);
        @(negedge CLK);
        bus.RX_DATA  = blk[7:0];
        bus.RX_READY = 1'b1;
        @(negedge CLK);
        bus.RX_READY = 1'b0;
        n = 1;
        check("fn_in_update", {192'h0, bus.FN_IN}, {192'h0, blk});
        while (bus.TX_START !== 1'b1 && n < 64) begin
            @(negedge CLK);
            n++;
        end
        check("latency", n, SETTLE + 2);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.BUSY !== 1'b0 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        check("idle_reached", {255'h0, n < 2000}, 256'h1);
    endtask

    initial begin
        int e0, t0, t1, n;
        logic [63:0] blk, ex;
        bus.RX_DATA  = 8'h00;
        bus.RX_READY = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_tx_start", {255'h0, bus.TX_START}, 256'h0);
        check("rst_tx_data", {248'h0, bus.TX_DATA}, 256'h0);
        check("rst_err", {255'h0, bus.ERR}, 256'h0);
        check("rst_busy", {255'h0, bus.BUSY}, 256'h0);
        check("rst_fn_in", {192'h0, bus.FN_IN}, 256'h0);
        check("rst_last_out", {192'h0, bus.LAST_OUT}, 256'h0);
        check("rst_fn_key", bus.FN_KEY, KEY0);
        RST = 1'b0;
        cur_key = KEY0;
        cur_blk = '0;

        vecs[0] = '{8'h45, 64'h0102030405060708, ref_fn(64'h0102030405060708, KEY0)};
        vecs[1] = '{8'h5A, 64'h0, {RSP_NAK, 56'h0}};
        vecs[2] = '{8'h45, 64'hFFFFFFFFFFFFFFFF, ref_fn(64'hFFFFFFFFFFFFFFFF, KEY0)};
        vecs[3] = '{8'h00, 64'h0, {RSP_NAK, 56'h0}};
        vecs[4] = '{8'h45, 64'h0000000000000000, ref_fn(64'h0000000000000000, KEY0)};
        vecs[5] = '{8'hFF, 64'h0, {RSP_NAK, 56'h0}};

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].cmd == CMD_ENC) begin
                push_reply(vecs[i].exp);
                send_block(vecs[i].blk);
                cur_blk = vecs[i].blk;
                wait_idle();
                check("last_out", {192'h0, bus.LAST_OUT}, {192'h0, vecs[i].exp});
            end else begin
                e0 = err_cnt;
                exp_q.push_back(vecs[i].exp[63:56]);
                send_byte(vecs[i].cmd);
                wait_idle();
                check("bad_err", err_cnt, e0 + 1);
                check("bad_fn_in", {192'h0, bus.FN_IN}, {192'h0, cur_blk});
                check("bad_fn_key", bus.FN_KEY, cur_key);
            end
            check("reply_drained", exp_q.size(), 0);
        end

        // Key load, then a block under the new key.
        exp_q.push_back(RSP_ACK);
        send_byte(CMD_KEY);
        for (int b = 0; b < 32; b++) send_byte(8'h00);
        wait_idle();
        check("key_loaded", bus.FN_KEY, 256'h0);
        check("key_ack_drained", exp_q.size(), 0);
        cur_key = '0;
        blk = 64'h0102030405060708;
        push_reply(ref_fn(blk, cur_key));
        send_block(blk);
        cur_blk = blk;
        wait_idle();
        check("new_key_out", {192'h0, bus.LAST_OUT}, {192'h0, ref_fn(blk, cur_key)});

        // Partial frame abandoned by the inter-byte timeout.
        e0 = err_cnt;
        t0 = tx_cnt;
        send_byte(CMD_ENC);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        repeat (TIMEOUT + 5) @(negedge CLK);
        check("to_err", err_cnt, e0 + 1);
        check("to_busy", {255'h0, bus.BUSY}, 256'h0);
        check("to_no_tx", tx_cnt, t0);
        check("to_fn_in", {192'h0, bus.FN_IN}, {192'h0, cur_blk});

        // A byte landing exactly on the timeout cycle is still accepted.
        e0 = err_cnt;
        blk = 64'hA1B2C3D4E5F60718;
        ex = ref_fn(blk, cur_key);
        push_reply(ex);
        send_byte(CMD_ENC);
        send_byte(blk[63:56]);
        repeat (TIMEOUT - 2) @(negedge CLK);
        for (int b = 6; b >= 0; b--) send_byte(blk[b*8 +: 8]);
        wait_idle();
        cur_blk = blk;
        check("edge_no_err", err_cnt, e0);
        check("edge_last_out", {192'h0, bus.LAST_OUT}, {192'h0, ex});
        check("edge_drained", exp_q.size(), 0);

        // A byte arriving while the reply is in flight is dropped.
        e0 = err_cnt;
        blk = 64'h1122334455667788;
        push_reply(ref_fn(blk, cur_key));
        send_block(blk);
        send_byte(CMD_ENC);
        wait_idle();
        cur_blk = blk;
        check("drop_err", err_cnt, e0 + 1);
        check("drop_drained", exp_q.size(), 0);
        repeat (TIMEOUT + 10) @(negedge CLK);
        check("drop_no_frame", err_cnt, e0 + 1);
        check("drop_busy", {255'h0, bus.BUSY}, 256'h0);

        // Reset in the middle of the reply stream.
        t0 = tx_cnt;
        blk = 64'hCAFEF00DDEADBEEF;
        push_reply(ref_fn(blk, cur_key));
        send_block(blk);
        n = 0;
        while (tx_cnt < t0 + 4 && n < 500) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("rst_4th_start", {255'h0, n < 500}, 256'h1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_q.delete();
        t1 = tx_cnt;
        repeat (30) @(negedge CLK);
        check("mid_rst_no_tx", tx_cnt, t1);
        check("mid_rst_busy", {255'h0, bus.BUSY}, 256'h0);
        check("mid_rst_key", bus.FN_KEY, KEY0);
        check("mid_rst_fn_in", {192'h0, bus.FN_IN}, 256'h0);
        check("mid_rst_tx_data", {248'h0, bus.TX_DATA}, 256'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
